// File: rtl/jump_redirect_unit_pkg.sv
// Shared definitions for the jump/branch/system redirect path: class bit indices,
// decoded class enum, FSM state encoding and the priority class decoder.
package jump_redirect_unit_pkg;

   localparam int unsigned XLEN_DEF        = 32;
   localparam int unsigned CLS_W           = 12;
   localparam int unsigned ECALL_CAUSE_DEF = 11;

   // One-hot class bit positions, common with the pre-decoder
   localparam int unsigned EJB_EBREAK   = 0;
   localparam int unsigned EJB_ECALL    = 1;
   localparam int unsigned EJB_MRET     = 2;
   localparam int unsigned EJB_JAL      = 3;
   localparam int unsigned EJB_JALR     = 4;
   localparam int unsigned EJB_BEQ      = 5;
   localparam int unsigned EJB_BNE      = 6;
   localparam int unsigned EJB_BGE      = 7;
   localparam int unsigned EJB_BGEU     = 8;
   localparam int unsigned EJB_BLTU     = 9;
   localparam int unsigned EJB_BLT      = 10;
   localparam int unsigned EJB_NOT_JUMP = 11;

   typedef enum logic [3:0] {
      CLS_EBREAK   = 4'd0,
      CLS_ECALL    = 4'd1,
      CLS_MRET     = 4'd2,
      CLS_JAL      = 4'd3,
      CLS_JALR     = 4'd4,
      CLS_BEQ      = 4'd5,
      CLS_BNE      = 4'd6,
      CLS_BGE      = 4'd7,
      CLS_BGEU     = 4'd8,
      CLS_BLTU     = 4'd9,
      CLS_BLT      = 4'd10,
      CLS_NOT_JUMP = 4'd11
   } cls_e;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REDIR = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   // Lowest set bit wins; an all-zero code falls through to not_jump
   function automatic cls_e cls_decode(input logic [CLS_W-1:0] cls);
      cls_e res;
      res = CLS_NOT_JUMP;
      for (int i = CLS_W - 1; i >= 0; i--) begin
         if (cls[i]) res = cls_e'(4'(i));
      end
      return res;
   endfunction

endpackage

// File: rtl/jump_redirect_unit_branch_cmp.sv
// Combinational branch resolution: decoded class plus operands to taken.
module jump_redirect_unit_branch_cmp
   import jump_redirect_unit_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic [CLS_W-1:0] i_cls,
   input  logic [XLEN-1:0]  i_rs1_val,
   input  logic [XLEN-1:0]  i_rs2_val,
   output logic             o_taken_c
);

   logic w_eq;
   logic w_lt_s;
   logic w_lt_u;

   assign w_eq   = (i_rs1_val == i_rs2_val);
   assign w_lt_s = ($signed(i_rs1_val) < $signed(i_rs2_val));
   assign w_lt_u = (i_rs1_val < i_rs2_val);

   always_comb begin
      o_taken_c = 1'b0;
      case (cls_decode(i_cls))
         CLS_BEQ:  o_taken_c = w_eq;
         CLS_BNE:  o_taken_c = ~w_eq;
         CLS_BLT:  o_taken_c = w_lt_s;
         CLS_BGE:  o_taken_c = ~w_lt_s;
         CLS_BLTU: o_taken_c = w_lt_u;
         CLS_BGEU: o_taken_c = ~w_lt_u;
         default:  o_taken_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/jump_redirect_unit.sv
// Resolves branches, jal/jalr and ecall/mret into a fetch redirect with flush,
// keeps mepc/mcause and a sticky ebreak halt.
module jump_redirect_unit
   import jump_redirect_unit_pkg::*;
#(
   parameter int unsigned XLEN        = XLEN_DEF,
   parameter int unsigned ECALL_CAUSE = ECALL_CAUSE_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [CLS_W-1:0] i_cls,
   input  logic [XLEN-1:0]  i_pc,
   input  logic [XLEN-1:0]  i_rs1_val,
   input  logic [XLEN-1:0]  i_rs2_val,
   input  logic [XLEN-1:0]  i_imm,
   input  logic [XLEN-1:0]  i_mtvec,
   output logic             o_redirect_valid,
   input  logic             i_redirect_ready,
   output logic [XLEN-1:0]  o_redirect_pc,
   output logic             o_flush,
   output logic             o_link_we,
   output logic [XLEN-1:0]  o_link_data,
   output logic [XLEN-1:0]  o_mepc,
   output logic [XLEN-1:0]  o_mcause,
   output logic             o_halt
);

   logic [1:0]      r_state,          w_state_d;
   logic            r_in_ready,       w_in_ready_d;
   logic            r_redirect_valid, w_redirect_valid_d;
   logic [XLEN-1:0] r_redirect_pc,    w_redirect_pc_d;
   logic            r_flush,          w_flush_d;
   logic            r_link_we,        w_link_we_d;
   logic [XLEN-1:0] r_link_data,      w_link_data_d;
   logic [XLEN-1:0] r_mepc,           w_mepc_d;
   logic [XLEN-1:0] r_mcause,         w_mcause_d;
   logic            r_halt,           w_halt_d;

   cls_e            w_cls;
   logic            w_taken_c;
   logic            w_accept;
   logic            w_redir;
   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_pc_imm;
   logic [XLEN-1:0] w_jalr_tgt;
   logic [XLEN-1:0] w_pc4;

   jump_redirect_unit_branch_cmp #(
      .XLEN (XLEN)
   ) u_branch_cmp (
      .i_cls     (i_cls),
      .i_rs1_val (i_rs1_val),
      .i_rs2_val (i_rs2_val),
      .o_taken_c (w_taken_c)
   );

   assign w_cls      = cls_decode(i_cls);
   assign w_accept   = i_in_valid & r_in_ready & (r_state == ST_IDLE);
   assign w_pc_imm   = i_pc + i_imm;
   assign w_jalr_tgt = (i_rs1_val + i_imm) & ~XLEN'(1);
   assign w_pc4      = i_pc + XLEN'(4);

   // Next-state and next-output logic; flush and link_we default low so they pulse
   always_comb begin
      w_state_d          = r_state;
      w_redirect_valid_d = r_redirect_valid;
      w_redirect_pc_d    = r_redirect_pc;
      w_flush_d          = 1'b0;
      w_link_we_d        = 1'b0;
      w_link_data_d      = r_link_data;
      w_mepc_d           = r_mepc;
      w_mcause_d         = r_mcause;
      w_halt_d           = r_halt;
      w_redir            = 1'b0;
      w_target           = '0;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (w_cls)
                  CLS_EBREAK: begin
                     w_halt_d  = 1'b1;
                     w_state_d = ST_HALT;
                  end
                  CLS_ECALL: begin
                     w_redir    = 1'b1;
                     w_target   = i_mtvec;
                     w_mepc_d   = i_pc;
                     w_mcause_d = XLEN'(ECALL_CAUSE);
                  end
                  // Return target is mepc as it stood before this edge
                  CLS_MRET: begin
                     w_redir  = 1'b1;
                     w_target = r_mepc;
                  end
                  CLS_JAL: begin
                     w_redir       = 1'b1;
                     w_target      = w_pc_imm;
                     w_link_we_d   = 1'b1;
                     w_link_data_d = w_pc4;
                  end
                  CLS_JALR: begin
                     w_redir       = 1'b1;
                     w_target      = w_jalr_tgt;
                     w_link_we_d   = 1'b1;
                     w_link_data_d = w_pc4;
                  end
                  CLS_BEQ, CLS_BNE, CLS_BGE, CLS_BGEU, CLS_BLTU, CLS_BLT: begin
                     w_redir  = w_taken_c;
                     w_target = w_pc_imm;
                  end
                  default: w_redir = 1'b0;
               endcase

               if (w_redir) begin
                  w_redirect_valid_d = 1'b1;
                  w_redirect_pc_d    = w_target;
                  w_flush_d          = 1'b1;
                  w_state_d          = ST_REDIR;
               end
            end
         end
         ST_REDIR: begin
            if (r_redirect_valid && i_redirect_ready) begin
               w_redirect_valid_d = 1'b0;
               w_state_d          = ST_IDLE;
            end
         end
         ST_HALT:  w_state_d = ST_HALT;
         default:  w_state_d = ST_IDLE;
      endcase

      w_in_ready_d = (w_state_d == ST_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state          <= ST_IDLE;
         r_in_ready       <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_flush          <= 1'b0;
         r_link_we        <= 1'b0;
         r_link_data      <= '0;
         r_mepc           <= '0;
         r_mcause         <= '0;
         r_halt           <= 1'b0;
      end else begin
         r_state          <= w_state_d;
         r_in_ready       <= w_in_ready_d;
         r_redirect_valid <= w_redirect_valid_d;
         r_redirect_pc    <= w_redirect_pc_d;
         r_flush          <= w_flush_d;
         r_link_we        <= w_link_we_d;
         r_link_data      <= w_link_data_d;
         r_mepc           <= w_mepc_d;
         r_mcause         <= w_mcause_d;
         r_halt           <= w_halt_d;
      end
   end

   assign o_in_ready       = r_in_ready;
   assign o_redirect_valid = r_redirect_valid;
   assign o_redirect_pc    = r_redirect_pc;
   assign o_flush          = r_flush;
   assign o_link_we        = r_link_we;
   assign o_link_data      = r_link_data;
   assign o_mepc           = r_mepc;
   assign o_mcause         = r_mcause;
   assign o_halt           = r_halt;

endmodule

// File: tb/tb_jump_redirect_unit.sv
// Bench for jump_redirect_unit: vector table driven through a scoreboard, plus
// hand sequences for redirect stall with async reset and the ebreak halt.
module tb_jump_redirect_unit;

   typedef struct {
      logic        redir;
      logic [31:0] rpc;
      logic        lwe;
      logic [31:0] ldata;
      logic [31:0] mepc;
      logic [31:0] mcause;
      logic        halt;
   } exp_t;

   typedef struct {
      logic [11:0] cls;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic [31:0] mtvec;
      exp_t        e;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] cls;
   logic [31:0] pc, rs1_val, rs2_val, imm, mtvec;
   logic        redirect_valid;
   logic        redirect_ready;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        link_we;
   logic [31:0] link_data;
   logic [31:0] mepc, mcause;
   logic        halt;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   exp_t cur_exp;
   logic pend = 1'b0;
   vec_t vecs[14];

   jump_redirect_unit dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_in_valid       (in_valid),
      .o_in_ready       (in_ready),
      .i_cls            (cls),
      .i_pc             (pc),
      .i_rs1_val        (rs1_val),
      .i_rs2_val        (rs2_val),
      .i_imm            (imm),
      .i_mtvec          (mtvec),
      .o_redirect_valid (redirect_valid),
      .i_redirect_ready (redirect_ready),
      .o_redirect_pc    (redirect_pc),
      .o_flush          (flush),
      .o_link_we        (link_we),
      .o_link_data      (link_data),
      .o_mepc           (mepc),
      .o_mcause         (mcause),
      .o_halt           (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic vec_t mk(input logic [11:0] c, input logic [31:0] p, r1, r2, im, mt,
                               input logic rd, input logic [31:0] rp, input logic lw,
                               input logic [31:0] ld, me, mc);
      vec_t v;
      v.cls = c; v.pc = p; v.rs1 = r1; v.rs2 = r2; v.imm = im; v.mtvec = mt;
      v.e.redir = rd; v.e.rpc = rp; v.e.lwe = lw; v.e.ldata = ld;
      v.e.mepc = me; v.e.mcause = mc; v.e.halt = 1'b0;
      return v;
   endfunction

   // Scoreboard push: a bundle is accepted on a rising edge with valid and ready high
   initial forever begin
      @(posedge clk);
      if (rst && in_valid && in_ready) begin
         exp_q.push_back(cur_exp);
         pend = 1'b1;
      end
   end

   // Scoreboard pop: registered results of the accept are visible by the falling edge
   initial forever begin
      @(negedge clk);
      if (pend) begin
         exp_t e;
         pend = 1'b0;
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("flush", 32'(flush), 32'(e.redir));
            chk("redirect_valid", 32'(redirect_valid), 32'(e.redir));
            if (e.redir) chk("redirect_pc", redirect_pc, e.rpc);
            chk("link_we", 32'(link_we), 32'(e.lwe));
            if (e.lwe) chk("link_data", link_data, e.ldata);
            chk("mepc", mepc, e.mepc);
            chk("mcause", mcause, e.mcause);
            chk("halt", 32'(halt), 32'(e.halt));
            chk("in_ready_after", 32'(in_ready), 32'(!(e.redir || e.halt)));
         end
      end
   end

   // Call at a falling edge; returns at the falling edge after the accept edge
   task automatic send(input vec_t v);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      cls = v.cls; pc = v.pc; rs1_val = v.rs1; rs2_val = v.rs2; imm = v.imm; mtvec = v.mtvec;
      cur_exp  = v.e;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t ve;
      logic [31:0] hold_pc;

      vecs[0]  = mk(12'h020, 32'h8000_0010, 32'd5, 32'd5, 32'h20, 32'h0, 1, 32'h8000_0030, 0, 0, 0, 0);
      vecs[1]  = mk(12'h400, 32'h0000_0100, 32'hFFFF_FFFF, 32'd1, 32'h40, 0, 1, 32'h0000_0140, 0, 0, 0, 0);
      vecs[2]  = mk(12'h200, 32'h0000_0100, 32'hFFFF_FFFF, 32'd1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
      vecs[3]  = mk(12'h080, 32'h0000_0100, 32'hFFFF_FFFF, 32'd1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
      vecs[4]  = mk(12'h100, 32'h0000_0200, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 0, 1, 32'h0000_01F8, 0, 0, 0, 0);
      vecs[5]  = mk(12'h040, 32'h0000_0300, 32'd3, 32'd3, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      vecs[6]  = mk(12'h800, 32'h0000_0304, 32'd3, 32'd4, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      vecs[7]  = mk(12'h000, 32'h0000_0308, 32'd3, 32'd4, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      vecs[8]  = mk(12'h010, 32'h8000_0000, 32'h8000_0103, 0, 32'h0, 0, 1, 32'h8000_0102, 1, 32'h8000_0004, 0, 0);
      vecs[9]  = mk(12'h008, 32'hFFFF_FFF0, 0, 0, 32'h20, 0, 1, 32'h0000_0010, 1, 32'hFFFF_FFF4, 0, 0);
      vecs[10] = mk(12'h028, 32'h0000_1000, 32'd1, 32'd2, 32'h10, 0, 1, 32'h0000_1010, 1, 32'h0000_1004, 0, 0);
      vecs[11] = mk(12'h002, 32'h8000_0040, 0, 0, 0, 32'h8000_1000, 1, 32'h8000_1000, 0, 0, 32'h8000_0040, 32'd11);
      vecs[12] = mk(12'h004, 32'h9000_0000, 0, 0, 0, 32'h8000_1000, 1, 32'h8000_0040, 0, 0, 32'h8000_0040, 32'd11);
      vecs[13] = mk(12'h0C0, 32'h0000_0300, 32'd3, 32'd3, 32'h10, 0, 0, 0, 0, 0, 32'h8000_0040, 32'd11);

      rst = 1'b0; in_valid = 1'b0; redirect_ready = 1'b1;
      cls = '0; pc = '0; rs1_val = '0; rs2_val = '0; imm = '0; mtvec = '0;
      cur_exp = vecs[0].e;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_link_we", 32'(link_we), 32'd0);
      chk("rst_link_data", link_data, 32'd0);
      chk("rst_mepc", mepc, 32'd0);
      chk("rst_mcause", mcause, 32'd0);
      chk("rst_halt", 32'(halt), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 14; i++) send(vecs[i]);
      @(negedge clk);
      chk("idle_after_table", 32'(in_ready), 32'd1);

      // jal with fetch stalled: redirect held stable, then async reset drops it
      redirect_ready = 1'b0;
      ve = mk(12'h008, 32'h0000_0400, 0, 0, 32'h100, 0, 1, 32'h0000_0500, 1, 32'h0000_0404,
              32'h8000_0040, 32'd11);
      send(ve);
      hold_pc = 32'h0000_0500;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("stall_redirect_valid", 32'(redirect_valid), 32'd1);
         chk("stall_redirect_pc", redirect_pc, hold_pc);
         chk("stall_flush", 32'(flush), 32'd0);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      #2 rst = 1'b0;
      #1;
      chk("async_rst_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("async_rst_mepc", mepc, 32'd0);
      chk("async_rst_mcause", mcause, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      redirect_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("no_reissue_redirect_valid", 32'(redirect_valid), 32'd0);
         chk("no_reissue_flush", 32'(flush), 32'd0);
      end
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // ebreak halts; later bundles are ignored
      ve = mk(12'h001, 32'h0000_0600, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      ve.e.halt = 1'b1;
      send(ve);
      cls = 12'h008; pc = 32'h0000_0700; imm = 32'h40; in_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("halt_sticky", 32'(halt), 32'd1);
         chk("halt_in_ready", 32'(in_ready), 32'd0);
         chk("halt_redirect_valid", 32'(redirect_valid), 32'd0);
         chk("halt_flush", 32'(flush), 32'd0);
         chk("halt_link_we", 32'(link_we), 32'd0);
      end
      in_valid = 1'b0;
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("halt_cleared", 32'(halt), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("halt_exit_in_ready", 32'(in_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
